// File: rtl/risc32_io_pkg.sv
// rtl/risc32_io_pkg.sv - shared encodings for the Risc32 I/O bridge
package risc32_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } io_state_t;

  localparam logic [2:0] SIZE_B  = 3'b000;
  localparam logic [2:0] SIZE_H  = 3'b001;
  localparam logic [2:0] SIZE_W  = 3'b010;
  localparam logic [2:0] SIZE_BU = 3'b100;
  localparam logic [2:0] SIZE_HU = 3'b101;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_DECODE   = 3'd1,
    ERR_MISALIGN = 3'd2,
    ERR_BOTH_EN  = 3'd3,
    ERR_TIMEOUT  = 3'd4
  } io_err_t;

  // Reserved size codes (011, 11x) count as misaligned so they always fault.
  function automatic logic size_misaligned(input logic [2:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SIZE_B, SIZE_BU: bad = 1'b0;
      SIZE_H, SIZE_HU: bad = lo[0];
      SIZE_W:          bad = (lo != 2'b00);
      default:         bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/risc32_io_bridge_if.sv
// rtl/risc32_io_bridge_if.sv - core-side and channel-side bus bundles of the I/O bridge
interface risc32_io_core_if #(
  parameter int DATA_W = 32
);
  logic [31:0]       io_address;
  logic [DATA_W-1:0] io_write_value;
  logic [DATA_W-1:0] io_read_value;
  logic              io_write_en;
  logic              io_read_en;
  logic [2:0]        io_data_size;
  logic              io_stall;
  logic              io_error;

  modport master (
    output io_address, io_write_value, io_write_en, io_read_en, io_data_size,
    input  io_read_value, io_stall, io_error
  );
  modport slave (
    input  io_address, io_write_value, io_write_en, io_read_en, io_data_size,
    output io_read_value, io_stall, io_error
  );
endinterface

interface risc32_io_ch_if #(
  parameter int NUM_CH       = 4,
  parameter int DATA_W       = 32,
  parameter int CH_ADDR_BITS = 12
);
  logic [NUM_CH-1:0]        ch_req;
  logic [CH_ADDR_BITS-1:0]  ch_addr;
  logic [DATA_W-1:0]        ch_wdata;
  logic                     ch_we;
  logic [2:0]               ch_size;
  logic [NUM_CH-1:0]        ch_ready;
  logic [NUM_CH*DATA_W-1:0] ch_rdata;

  modport master (
    output ch_req, ch_addr, ch_wdata, ch_we, ch_size,
    input  ch_ready, ch_rdata
  );
  modport slave (
    input  ch_req, ch_addr, ch_wdata, ch_we, ch_size,
    output ch_ready, ch_rdata
  );
endinterface

// File: rtl/risc32_io_decode.sv
// rtl/risc32_io_decode.sv - combinational window hit, channel index, offset and alignment check
module risc32_io_decode
  import risc32_io_pkg::*;
#(
  parameter int          NUM_CH       = 4,
  parameter int          CH_ADDR_BITS = 12,
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  localparam int         IDX_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [31:0]             address,
  input  logic [2:0]              size,
  output logic                    hit,
  output logic [IDX_W-1:0]        idx,
  output logic [CH_ADDR_BITS-1:0] offset,
  output logic                    misalign
);
  localparam int TAG_LSB = CH_ADDR_BITS + IDX_W;

  assign idx      = address[CH_ADDR_BITS +: IDX_W];
  assign offset   = address[CH_ADDR_BITS-1:0];
  assign hit      = (address[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]) &&
                    (32'(idx) < $unsigned(NUM_CH));
  assign misalign = size_misaligned(size, address[1:0]);

endmodule

// File: rtl/risc32_io_bridge.sv
// rtl/risc32_io_bridge.sv - Risc32 data-port to NUM_CH peripheral channel bridge
// Decodes core accesses, holds one channel request until ready or timeout, stalls the core.
module risc32_io_bridge
  import risc32_io_pkg::*;
#(
  parameter int          NUM_CH       = 4,
  parameter int          DATA_W       = 32,
  parameter int          CH_ADDR_BITS = 12,
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter int          TIMEOUT      = 15
) (
  input logic            clk,
  input logic            rst_n,
  risc32_io_core_if.slave core,
  risc32_io_ch_if.master  ch
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  io_state_t               state_q, state_d;
  io_err_t                 cause;
  logic [IDX_W-1:0]        idx_q;
  logic [7:0]              cnt_q;
  logic                    err_q;
  logic [DATA_W-1:0]       rdata_q;
  logic                    hit, misalign;
  logic [IDX_W-1:0]        dec_idx;
  logic [CH_ADDR_BITS-1:0] dec_off;
  logic                    en, start, ready, expire;

  risc32_io_decode #(
    .NUM_CH       (NUM_CH),
    .CH_ADDR_BITS (CH_ADDR_BITS),
    .BASE_ADDR    (BASE_ADDR)
  ) u_decode (
    .address  (core.io_address),
    .size     (core.io_data_size),
    .hit      (hit),
    .idx      (dec_idx),
    .offset   (dec_off),
    .misalign (misalign)
  );

  // Gating with rst_n keeps stall/error quiet while reset is held with a request pending.
  assign en     = rst_n && (core.io_read_en || core.io_write_en);
  assign ready  = ch.ch_ready[idx_q];
  assign expire = (cnt_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d            = state_q;
    start              = 1'b0;
    cause              = ERR_NONE;
    core.io_stall      = 1'b0;
    core.io_read_value = '0;
    ch.ch_req          = '0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          if (!hit)                                        cause = ERR_DECODE;
          else if (misalign)                               cause = ERR_MISALIGN;
          else if (core.io_read_en && core.io_write_en)    cause = ERR_BOTH_EN;
          else begin
            start         = 1'b1;
            core.io_stall = 1'b1;
            state_d       = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        core.io_stall    = 1'b1;
        ch.ch_req[idx_q] = 1'b1;
        if (ready || expire) state_d = ST_DONE;
      end
      ST_DONE: begin
        core.io_read_value = rdata_q;
        if (err_q) cause = ERR_TIMEOUT;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    core.io_error = (cause != ERR_NONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      ch.ch_addr  <= '0;
      ch.ch_wdata <= '0;
      ch.ch_we    <= 1'b0;
      ch.ch_size  <= '0;
    end else begin
      if (start) begin
        idx_q       <= dec_idx;
        cnt_q       <= '0;
        err_q       <= 1'b0;
        ch.ch_addr  <= dec_off;
        ch.ch_wdata <= core.io_write_value;
        ch.ch_we    <= core.io_write_en;
        ch.ch_size  <= core.io_data_size;
      end
      if (state_q == ST_REQ) begin
        cnt_q <= cnt_q + 8'd1;
        // Ready has priority over a timeout landing in the same cycle.
        if (ready) begin
          rdata_q <= ch.ch_we ? '0 : ch.ch_rdata[idx_q*DATA_W +: DATA_W];
        end else if (expire) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
      if (state_q == ST_DONE) begin
        err_q <= 1'b0;
        cnt_q <= '0;
      end
    end
  end

endmodule
